// File: rtl/gan_selftest_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : gan_selftest_seq_if                                            |
// | Purpose   : Bundles every non-clock/reset signal of the GAN self-test      |
// |             sequencer: run control, vector-table read port, GAN core       |
// |             launch/response port and the result/status outputs.           |
// | Modports  : master - the sequencer (drives busy, vec_addr, dut_*, results) |
// |             slave  - the environment (table, core, run requester)          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface gan_selftest_seq_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int LATENT_DIM  = 2,
  parameter int IMAGE_SIZE  = 9,
  parameter int NUM_VECTORS = 4
);
  localparam int ADDR_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int CNT_W  = $clog2(NUM_VECTORS + 1);

  // run control
  logic                               start;
  logic                               busy;
  logic                               run_done;
  // vector table read port (data valid the cycle after vec_addr)
  logic [ADDR_W-1:0]                  vec_addr;
  logic [1:0]                         vec_mode;
  logic [LATENT_DIM*DATA_WIDTH-1:0]   vec_latent;
  logic [IMAGE_SIZE*DATA_WIDTH-1:0]   vec_image;
  logic [DATA_WIDTH-1:0]              vec_exp_score;
  // GAN core port
  logic [1:0]                         dut_mode;
  logic                               dut_start;
  logic [LATENT_DIM*DATA_WIDTH-1:0]   dut_latent;
  logic [IMAGE_SIZE*DATA_WIDTH-1:0]   dut_image;
  logic                               dut_done;
  logic [IMAGE_SIZE*DATA_WIDTH-1:0]   dut_gen_image;
  logic [DATA_WIDTH-1:0]              dut_disc_score;
  // results
  logic [CNT_W-1:0]                   pass_count;
  logic [CNT_W-1:0]                   fail_count;
  logic [ADDR_W-1:0]                  first_fail;
  logic                               any_fail;
  logic                               timeout_flag;
  logic [31:0]                        signature;

  modport master (
    input  start, output busy, output run_done,
    output vec_addr, input vec_mode, input vec_latent, input vec_image, input vec_exp_score,
    output dut_mode, output dut_start, output dut_latent, output dut_image,
    input  dut_done, input dut_gen_image, input dut_disc_score,
    output pass_count, output fail_count, output first_fail, output any_fail,
    output timeout_flag, output signature
  );

  modport slave (
    output start, input busy, input run_done,
    input  vec_addr, output vec_mode, output vec_latent, output vec_image, output vec_exp_score,
    input  dut_mode, input dut_start, input dut_latent, input dut_image,
    output dut_done, output dut_gen_image, output dut_disc_score,
    input  pass_count, input fail_count, input first_fail, input any_fail,
    input  timeout_flag, input signature
  );
endinterface
`default_nettype wire

// File: rtl/gan_selftest_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : gan_selftest_seq                                               |
// | Purpose   : Directed self-test sequencer for the GAN core. Walks a table   |
// |             of NUM_VECTORS vectors, launches the core in each vector's     |
// |             mode, checks the result and accumulates pass/fail status.      |
// | Ports     : clk, rst_n (async, active low)                                 |
// |             bus - gan_selftest_seq_if.master (run control, table port,     |
// |                   core port, pass/fail counts, sticky flags, signature)    |
// | Option    : SELFTEST_MISR_EN - when defined, builds a 32-bit MISR over     |
// |             the generated images of mode 00/10 vectors; otherwise the      |
// |             signature output is tied to zero.                              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module gan_selftest_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LATENT_DIM  = 2,
  parameter int IMAGE_SIZE  = 9,
  parameter int NUM_VECTORS = 4,
  parameter int SCORE_TOL   = 8,
  parameter int TIMEOUT     = 1024,
  parameter int GAP_CYCLES  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gan_selftest_seq_if.master     bus
);
  localparam int ADDR_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int CNT_W   = $clog2(NUM_VECTORS + 1);
  localparam int LAT_W   = LATENT_DIM * DATA_WIDTH;
  localparam int IMG_W   = IMAGE_SIZE * DATA_WIDTH;
  localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int ONE_Q   = 1 << FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_CHECK  = 3'd5,
    S_GAP    = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [1:0]                mode_q, mode_d;
  logic [LAT_W-1:0]          latent_q, latent_d;
  logic [IMG_W-1:0]          image_q, image_d;
  logic [DATA_WIDTH-1:0]     exp_q, exp_d;
  logic [IMG_W-1:0]          res_img_q, res_img_d;
  logic [DATA_WIDTH-1:0]     res_score_q, res_score_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [CNT_W-1:0]          pass_q, pass_d;
  logic [CNT_W-1:0]          fail_q, fail_d;
  logic [ADDR_W-1:0]         first_q, first_d;
  logic                      any_q, any_d;
  logic                      tout_q, tout_d;

  // Result evaluation. The core response is captured on dut_done so the
  // check does not depend on the core holding its outputs afterwards.
  // The score difference is formed one bit wider than the data so that
  // extreme score/expected pairs cannot wrap.
  logic signed [DATA_WIDTH:0] score_x, exp_x, diff;
  logic [DATA_WIDTH:0]        diff_abs;
  logic                       score_in_range, score_close, check_pass;

  always_comb begin
    score_x        = $signed({res_score_q[DATA_WIDTH-1], res_score_q});
    exp_x          = $signed({exp_q[DATA_WIDTH-1], exp_q});
    diff           = score_x - exp_x;
    diff_abs       = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    score_in_range = !res_score_q[DATA_WIDTH-1] && (res_score_q <= DATA_WIDTH'(ONE_Q));
    score_close    = (diff_abs <= (DATA_WIDTH+1)'(SCORE_TOL));
    check_pass     = (mode_q == 2'b00) ? (|res_img_q) : (score_in_range && score_close);
  end

  logic pass_evt, fail_evt, goto_gap, next_vec;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    latent_d    = latent_q;
    image_d     = image_q;
    exp_d       = exp_q;
    res_img_d   = res_img_q;
    res_score_d = res_score_q;
    tmr_d       = tmr_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    first_d     = first_q;
    any_d       = any_q;
    tout_d      = tout_q;
    pass_evt    = 1'b0;
    fail_evt    = 1'b0;
    goto_gap    = 1'b0;
    next_vec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pass_d  = '0;
          fail_d  = '0;
          first_d = '0;
          any_d   = 1'b0;
          tout_d  = 1'b0;
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        mode_d   = bus.vec_mode;
        latent_d = bus.vec_latent;
        image_d  = bus.vec_image;
        exp_d    = bus.vec_exp_score;
        if (bus.vec_mode == 2'b11) begin
          fail_evt = 1'b1;
          goto_gap = 1'b1;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // dut_done seen here belongs to nothing we launched; not sampled.
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.dut_done) begin
          res_img_d   = bus.dut_gen_image;
          res_score_d = bus.dut_disc_score;
          state_d     = S_CHECK;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          tout_d   = 1'b1;
          fail_evt = 1'b1;
          goto_gap = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CHECK: begin
        pass_evt = check_pass;
        fail_evt = !check_pass;
        goto_gap = 1'b1;
      end
      S_GAP: begin
        if (tmr_q == TMR_W'(GAP_CYCLES - 1)) next_vec = 1'b1;
        else                                  tmr_d    = tmr_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A zero-length gap skips the GAP state entirely.
    if (goto_gap) begin
      if (GAP_CYCLES == 0) begin
        next_vec = 1'b1;
      end else begin
        tmr_d   = '0;
        state_d = S_GAP;
      end
    end

    if (next_vec) begin
      if (addr_q == ADDR_W'(NUM_VECTORS - 1)) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (pass_evt) pass_d = pass_q + 1'b1;
    if (fail_evt) begin
      fail_d = fail_q + 1'b1;
      any_d  = 1'b1;
      if (!any_q) first_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mode_q      <= '0;
      latent_q    <= '0;
      image_q     <= '0;
      exp_q       <= '0;
      res_img_q   <= '0;
      res_score_q <= '0;
      tmr_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      first_q     <= '0;
      any_q       <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      latent_q    <= latent_d;
      image_q     <= image_d;
      exp_q       <= exp_d;
      res_img_q   <= res_img_d;
      res_score_q <= res_score_d;
      tmr_q       <= tmr_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      first_q     <= first_d;
      any_q       <= any_d;
      tout_q      <= tout_d;
    end
  end

`ifdef SELFTEST_MISR_EN
  logic [31:0] sig_q, sig_d, fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      fold = fold ^ 32'(res_img_q[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    sig_d = sig_q;
    if (state_q == S_IDLE && bus.start) begin
      sig_d = '0;
    end else if (state_q == S_CHECK && (mode_q == 2'b00 || mode_q == 2'b10)) begin
      sig_d = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign bus.signature = sig_q;
`else
  assign bus.signature = '0;
`endif

  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.run_done     = (state_q == S_DONE);
  assign bus.vec_addr     = addr_q;
  assign bus.dut_mode     = mode_q;
  assign bus.dut_start    = (state_q == S_LAUNCH);
  assign bus.dut_latent   = latent_q;
  assign bus.dut_image    = image_q;
  assign bus.pass_count   = pass_q;
  assign bus.fail_count   = fail_q;
  assign bus.first_fail   = first_q;
  assign bus.any_fail     = any_q;
  assign bus.timeout_flag = tout_q;
endmodule
`default_nettype wire
